multi_cycle_control: RTL and testbench

MULTI_CYCLE_CONTROL -- requirements
Module: Multi_Cycle_Control

---
 rtl/multi_cycle_control_pkg.sv | 65 ++++++
 rtl/multi_cycle_control_decode.sv | 76 +++++++
 rtl/multi_cycle_control.sv | 95 +++++++++
 tb/tb_multi_cycle_control.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_control_pkg.sv
// Shared MIPS multi-cycle definitions: FSM state codes, opcodes, and mux/ALU selects.
package multi_cycle_control_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_R_EXEC   = 4'd7,
        ST_R_WB     = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_I_EXEC   = 4'd11,
        ST_I_WB     = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;
    localparam logic [1:0] ALUOP_OR    = 2'd3;

    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Per-state control word produced by the output decoder
    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       branch;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic       ext_op;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_J) || (op == OP_ADDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/multi_cycle_control_decode.sv
// Combinational per-state control decode for the multi-cycle MIPS controller.
module multi_cycle_control_decode
    import multi_cycle_control_pkg::*;
(
    input  state_e      state_i,
    input  logic [5:0]  opcode_i,
    input  logic        mem_ready_i,
    output ctrl_t       ctrl_o
);

    logic is_ori;
    assign is_ori = (opcode_i == OP_ORI);

    // Map the current state (and registered opcode) to datapath controls
    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            ST_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.ext_op    = 1'b1;
            end
            ST_MEM_ADDR, ST_I_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = is_ori ? ALUOP_OR : ALUOP_ADD;
                ctrl_o.ext_op    = ~is_ori;
            end
            ST_MEM_RD: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.mem_read = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            ST_R_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            ST_I_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_SUB;
                ctrl_o.branch    = 1'b1;
                ctrl_o.pc_source = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control unit: state register, opcode latch and next-state logic.
module multi_cycle_control
    import multi_cycle_control_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       mem_ready_i,
    output logic       PC_write_o,
    output logic       IorD_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       IR_write_o,
    output logic       branch_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       ALU_src_a_o,
    output logic       ext_op_o,
    output logic       illegal_o,
    output logic [1:0] ALU_src_b_o,
    output logic [1:0] ALU_op_o,
    output logic [1:0] PC_source_o,
    output logic [3:0] state_o
);

    state_e     state_q, state_d;
    logic [5:0] opcode_q;
    ctrl_t      ctrl;

    // funct goes straight to the ALU control unit; this block never looks at it
    logic unused_funct;
    assign unused_funct = ^funct_i;

    // Next-state selection; post-DECODE decisions use the latched opcode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     state_d = ST_FETCH;
            ST_FETCH:    if (mem_ready_i) state_d = ST_DECODE;
            ST_DECODE: begin
                if (opcode_i == OP_RTYPE)                           state_d = ST_R_EXEC;
                else if ((opcode_i == OP_LW) || (opcode_i == OP_SW)) state_d = ST_MEM_ADDR;
                else if (opcode_i == OP_BEQ)                        state_d = ST_BRANCH;
                else if (opcode_i == OP_J)                          state_d = ST_JUMP;
                else if ((opcode_i == OP_ADDI) || (opcode_i == OP_ORI)) state_d = ST_I_EXEC;
                else                                                state_d = ST_FETCH;
            end
            ST_MEM_ADDR: state_d = (opcode_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   if (mem_ready_i) state_d = ST_MEM_WB;
            ST_MEM_WR:   if (mem_ready_i) state_d = ST_FETCH;
            ST_R_EXEC:   state_d = ST_R_WB;
            ST_I_EXEC:   state_d = ST_I_WB;
            ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
            default:     state_d = ST_IDLE;
        endcase
    end

    // State and opcode registers; the opcode is latched as DECODE is left
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            opcode_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) opcode_q <= opcode_i;
        end
    end

    multi_cycle_control_decode u_decode (
        .state_i     (state_q),
        .opcode_i    (opcode_q),
        .mem_ready_i (mem_ready_i),
        .ctrl_o      (ctrl)
    );

    assign illegal_o    = (state_q == ST_DECODE) && !op_supported(opcode_i);
    assign PC_write_o   = ctrl.pc_write;
    assign IorD_o       = ctrl.iord;
    assign mem_read_o   = ctrl.mem_read;
    assign mem_write_o  = ctrl.mem_write;
    assign IR_write_o   = ctrl.ir_write;
    assign branch_o     = ctrl.branch;
    assign reg_dst_o    = ctrl.reg_dst;
    assign mem_to_reg_o = ctrl.mem_to_reg;
    assign reg_write_o  = ctrl.reg_write;
    assign ALU_src_a_o  = ctrl.alu_src_a;
    assign ext_op_o     = ctrl.ext_op;
    assign ALU_src_b_o  = ctrl.alu_src_b;
    assign ALU_op_o     = ctrl.alu_op;
    assign PC_source_o  = ctrl.pc_source;
    assign state_o      = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: directed instruction sequences.
module tb_multi_cycle_control;
    import multi_cycle_control_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       mem_ready;
    logic       PC_write, IorD, mem_read, mem_write, IR_write, branch, reg_dst;
    logic       mem_to_reg, reg_write, ALU_src_a, ext_op, illegal;
    logic [1:0] ALU_src_b, ALU_op, PC_source;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          id;
        logic [3:0]  st;
        logic [17:0] ov;
    } exp_t;
    exp_t exp_q[$];
    int   next_id = 0;

    // Expected output vectors, bit order:
    // PCw IorD mrd mwr IRw br rdst m2r rw srcA ext ill | srcB | aluop | pcsrc
    localparam logic [17:0] V_ZERO = 18'b0;
    localparam logic [17:0] V_FW   = 18'b0_0_1_0_0_0_0_0_0_0_0_0_01_00_00;
    localparam logic [17:0] V_FR   = 18'b1_0_1_0_1_0_0_0_0_0_0_0_01_00_00;
    localparam logic [17:0] V_DEC  = 18'b0_0_0_0_0_0_0_0_0_0_1_0_11_00_00;
    localparam logic [17:0] V_DECI = 18'b0_0_0_0_0_0_0_0_0_0_1_1_11_00_00;
    localparam logic [17:0] V_MADR = 18'b0_0_0_0_0_0_0_0_0_1_1_0_10_00_00;
    localparam logic [17:0] V_MRD  = 18'b0_1_1_0_0_0_0_0_0_0_0_0_00_00_00;
    localparam logic [17:0] V_MWR  = 18'b0_1_0_1_0_0_0_0_0_0_0_0_00_00_00;
    localparam logic [17:0] V_MWB  = 18'b0_0_0_0_0_0_0_1_1_0_0_0_00_00_00;
    localparam logic [17:0] V_REX  = 18'b0_0_0_0_0_0_0_0_0_1_0_0_00_10_00;
    localparam logic [17:0] V_RWB  = 18'b0_0_0_0_0_0_1_0_1_0_0_0_00_00_00;
    localparam logic [17:0] V_ORI  = 18'b0_0_0_0_0_0_0_0_0_1_0_0_10_11_00;
    localparam logic [17:0] V_IWB  = 18'b0_0_0_0_0_0_0_0_1_0_0_0_00_00_00;
    localparam logic [17:0] V_BR   = 18'b0_0_0_0_0_1_0_0_0_1_0_0_00_01_01;
    localparam logic [17:0] V_J    = 18'b1_0_0_0_0_0_0_0_0_0_0_0_00_00_10;

    multi_cycle_control dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .opcode_i     (opcode),
        .funct_i      (funct),
        .mem_ready_i  (mem_ready),
        .PC_write_o   (PC_write),
        .IorD_o       (IorD),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .IR_write_o   (IR_write),
        .branch_o     (branch),
        .reg_dst_o    (reg_dst),
        .mem_to_reg_o (mem_to_reg),
        .reg_write_o  (reg_write),
        .ALU_src_a_o  (ALU_src_a),
        .ext_op_o     (ext_op),
        .illegal_o    (illegal),
        .ALU_src_b_o  (ALU_src_b),
        .ALU_op_o     (ALU_op),
        .PC_source_o  (PC_source),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] out_vec();
        return {PC_write, IorD, mem_read, mem_write, IR_write, branch, reg_dst,
                mem_to_reg, reg_write, ALU_src_a, ext_op, illegal,
                ALU_src_b, ALU_op, PC_source};
    endfunction

    // Drive one cycle of stimulus and queue the response expected in that cycle
    task automatic cyc(input logic [5:0] opc, input logic rdy, input logic [3:0] st,
                       input logic [17:0] ov);
        exp_t e;
        @(posedge clk);
        #1;
        opcode    = opc;
        mem_ready = rdy;
        e.id = next_id; e.st = st; e.ov = ov;
        next_id++;
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs against the queued expectation each negedge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (state !== e.st) begin
                    errors++;
                    $display("FAIL state#%0d got %0d expected %0d", e.id, state, e.st);
                end
                checks++;
                if (out_vec() !== e.ov) begin
                    errors++;
                    $display("FAIL outputs#%0d got %b expected %b (state %0d)",
                             e.id, out_vec(), e.ov, state);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; opcode = '0; funct = 6'b100000; mem_ready = 1'b0;

        // Reset held 3 cycles, then release: IDLE then FETCH
        cyc(OP_LW, 1'b1, 4'd0, V_ZERO);
        cyc(OP_LW, 1'b1, 4'd0, V_ZERO);
        cyc(OP_LW, 1'b1, 4'd0, V_ZERO);
        @(posedge clk); #1; rst_n = 1'b1; mem_ready = 1'b0;
        begin exp_t e; e.id = next_id; e.st = 4'd0; e.ov = V_ZERO; next_id++; exp_q.push_back(e); end

        // lw with memory waits in FETCH and MEM_RD; opcode_i scrambled after DECODE
        cyc(OP_LW, 1'b0, 4'd1, V_FW);
        cyc(OP_LW, 1'b0, 4'd1, V_FW);
        cyc(OP_LW, 1'b1, 4'd1, V_FR);
        cyc(OP_LW, 1'b0, 4'd2, V_DEC);
        cyc(6'h3f, 1'b1, 4'd3, V_MADR);
        cyc(6'h3f, 1'b0, 4'd4, V_MRD);
        cyc(6'h3f, 1'b0, 4'd4, V_MRD);
        cyc(6'h3f, 1'b1, 4'd4, V_MRD);
        cyc(6'h3f, 1'b1, 4'd5, V_MWB);

        // R-type
        cyc(OP_RTYPE, 1'b1, 4'd1, V_FR);
        cyc(OP_RTYPE, 1'b0, 4'd2, V_DEC);
        cyc(OP_RTYPE, 1'b1, 4'd7, V_REX);
        cyc(OP_RTYPE, 1'b0, 4'd8, V_RWB);

        // ori: zero extend, OR
        cyc(OP_ORI, 1'b1, 4'd1, V_FR);
        cyc(OP_ORI, 1'b0, 4'd2, V_DEC);
        cyc(OP_ORI, 1'b0, 4'd11, V_ORI);
        cyc(OP_ORI, 1'b1, 4'd12, V_IWB);

        // addi: sign extend, add
        cyc(OP_ADDI, 1'b1, 4'd1, V_FR);
        cyc(OP_ADDI, 1'b0, 4'd2, V_DEC);
        cyc(OP_ADDI, 1'b0, 4'd11, V_MADR);
        cyc(OP_ADDI, 1'b0, 4'd12, V_IWB);

        // beq
        cyc(OP_BEQ, 1'b1, 4'd1, V_FR);
        cyc(OP_BEQ, 1'b0, 4'd2, V_DEC);
        cyc(OP_BEQ, 1'b1, 4'd9, V_BR);

        // j
        cyc(OP_J, 1'b1, 4'd1, V_FR);
        cyc(OP_J, 1'b0, 4'd2, V_DEC);
        cyc(OP_J, 1'b1, 4'd10, V_J);

        // illegal opcode: one-cycle pulse in DECODE, back to FETCH
        cyc(6'h3f, 1'b1, 4'd1, V_FR);
        cyc(6'h3f, 1'b0, 4'd2, V_DECI);
        cyc(6'h3f, 1'b0, 4'd1, V_FW);

        // sw complete
        cyc(OP_SW, 1'b1, 4'd1, V_FR);
        cyc(OP_SW, 1'b0, 4'd2, V_DEC);
        cyc(OP_SW, 1'b0, 4'd3, V_MADR);
        cyc(OP_SW, 1'b0, 4'd6, V_MWR);
        cyc(OP_SW, 1'b1, 4'd6, V_MWR);

        // sw aborted by reset while waiting in MEM_WR
        cyc(OP_SW, 1'b1, 4'd1, V_FR);
        cyc(OP_SW, 1'b0, 4'd2, V_DEC);
        cyc(OP_SW, 1'b0, 4'd3, V_MADR);
        cyc(OP_SW, 1'b0, 4'd6, V_MWR);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0) begin
            errors++;
            $display("FAIL async_mwr got %b expected 0", mem_write);
        end
        checks++;
        if (state !== 4'd0 || out_vec() !== V_ZERO) begin
            errors++;
            $display("FAIL async_all got state %0d outs %b expected state 0 outs 0", state, out_vec());
        end
        cyc(OP_SW, 1'b1, 4'd0, V_ZERO);
        cyc(OP_SW, 1'b1, 4'd0, V_ZERO);
        @(posedge clk); #1; rst_n = 1'b1; mem_ready = 1'b0;
        begin exp_t e; e.id = next_id; e.st = 4'd0; e.ov = V_ZERO; next_id++; exp_q.push_back(e); end
        cyc(OP_SW, 1'b0, 4'd1, V_FW);
        cyc(OP_SW, 1'b0, 4'd1, V_FW);

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
